// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage bridge to a 16-bit asynchronous SRAM.
// Each 32-bit load/store is split into a low-half and a high-half SRAM
// access. The access is padded with wait cycles so that the total stall is
// LATENCY cycles. ready drops combinationally in the first request cycle so
// the pipeline freezes immediately. ready rises for exactly one DONE cycle.
module sram_mem_controller #(
    parameter int LATENCY = 6,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WAIT,
        S_DONE
    } state_t;

    // Last WAIT count before DONE; only meaningful when LATENCY > 3.
    localparam int                 WAIT_LAST_I = (LATENCY > 3) ? (LATENCY - 4) : 0;
    localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(WAIT_LAST_I);
    localparam logic               HAS_WAIT    = (LATENCY > 3);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [16:0]      word_q;
    logic [31:0]      wdata_q;
    logic             is_wr_q;
    logic [31:0]      rdata_q;
    logic [15:0]      dq_out;
    logic             req;
    logic             unused_addr_bits;

    assign req              = wr_en | rd_en;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    // State and wait counter; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request only on the IDLE->LO edge so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req) begin
            word_q  <= address[18:2];
            wdata_q <= write_data;
            is_wr_q <= wr_en;
        end
    end

    // Load result assembled half by half at the closing edge of LO and HI.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (!is_wr_q && state_q == S_LO) begin
            rdata_q[15:0] <= SRAM_DQ;
        end else if (!is_wr_q && state_q == S_HI) begin
            rdata_q[31:16] <= SRAM_DQ;
        end
    end

    // Next-state logic and SRAM strobes; the bus is touched only in LO and HI.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        ready     = 1'b0;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_out    = '0;
        case (state_q)
            S_IDLE: begin
                ready = ~req;
                if (req) state_d = S_LO;
            end
            S_LO: begin
                SRAM_ADDR = {word_q, 1'b0};
                if (is_wr_q) begin
                    SRAM_WE_N = 1'b0;
                    dq_out    = wdata_q[15:0];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                state_d = S_HI;
            end
            S_HI: begin
                SRAM_ADDR = {word_q, 1'b1};
                if (is_wr_q) begin
                    SRAM_WE_N = 1'b0;
                    dq_out    = wdata_q[31:16];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                state_d = HAS_WAIT ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = S_DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drive the bus only while writing, so it can never contend with the SRAM.
    assign SRAM_DQ   = SRAM_WE_N ? 16'bz : dq_out;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Testbench for sram_mem_controller: a LATENCY=6 instance checked by a
// scoreboard/monitor pair, and a LATENCY=3 instance checked cycle by cycle.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst;
    // LATENCY = 6 instance
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] rdata6;
    logic        ready6, we6, oe6;
    logic [17:0] addr6;
    wire  [15:0] dq6;
    // LATENCY = 3 instance
    logic        wr3, rd3;
    logic [31:0] a3, d3;
    logic [31:0] rdata3;
    logic        ready3, we3, oe3;
    logic [17:0] addr3;
    wire  [15:0] dq3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_mem_controller #(.LATENCY(6), .CNT_W(4)) dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(rdata6), .ready(ready6),
        .SRAM_ADDR(addr6), .SRAM_DQ(dq6), .SRAM_WE_N(we6), .SRAM_OE_N(oe6));

    sram_mem_controller #(.LATENCY(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3), .address(a3),
        .write_data(d3), .read_data(rdata3), .ready(ready3),
        .SRAM_ADDR(addr3), .SRAM_DQ(dq3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3));

    // Asynchronous SRAM models (256 halfwords each, low address bits only)
    logic [15:0] mem6 [0:255];
    logic [15:0] mem3 [0:255];
    assign dq6 = (!oe6 && we6) ? mem6[addr6[7:0]] : 16'hzzzz;
    assign dq3 = (!oe3 && we3) ? mem3[addr3[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!we6) mem6[addr6[7:0]] <= dq6;
        if (!we3) mem3[addr3[7:0]] <= dq3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard entries
    typedef struct {
        bit          wr;
        logic [17:0] a_lo;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];
    logic [31:0] exp_rd;

    // Monitor state
    int          stalls;
    int          nact;
    bit          busy;
    logic [17:0] m_a  [0:1];
    logic [15:0] m_d  [0:1];
    logic        m_we [0:1];
    logic        m_oe [0:1];

    // Monitor: collect bus phases and stall cycles, compare on each completion
    always @(negedge clk) begin
        if (rst) begin
            stalls = 0; nact = 0; busy = 0;
        end else begin
            if (!we6 || !oe6) begin
                if (nact < 2) begin
                    m_a[nact]  = addr6;
                    m_d[nact]  = dq6;
                    m_we[nact] = we6;
                    m_oe[nact] = oe6;
                end
                nact++;
            end
            if (!ready6) begin
                stalls++;
                busy = 1;
            end else if (busy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("stall_cycles", stalls, 6);
                    chk("bus_phases", nact, 2);
                    if (nact == 2) begin
                        chk("lo_addr", {14'd0, m_a[0]}, {14'd0, e.a_lo});
                        chk("hi_addr", {14'd0, m_a[1]}, {14'd0, e.a_lo | 18'd1});
                        if (e.wr) begin
                            chk("wr_strobes", {m_we[0], m_we[1], m_oe[0], m_oe[1]}, 4'b0011);
                            chk("lo_dq", {16'd0, m_d[0]}, {16'd0, e.wdata[15:0]});
                            chk("hi_dq", {16'd0, m_d[1]}, {16'd0, e.wdata[31:16]});
                        end else begin
                            chk("rd_strobes", {m_we[0], m_we[1], m_oe[0], m_oe[1]}, 4'b1100);
                        end
                    end
                    chk("read_data", rdata6, e.rdata);
                end
                stalls = 0; nact = 0; busy = 0;
            end
        end
    end

    // Issue one access on the LATENCY=6 instance, starting just after a posedge
    task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rexp, input bit scramble);
        exp_t e;
        bit   done = 0;
        e.wr    = wr;
        e.a_lo  = {a[18:2], 1'b0};
        e.wdata = d;
        e.rdata = wr ? exp_rd : rexp;
        exp_rd  = e.rdata;
        sb_q.push_back(e);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (scramble && n == 1) begin
                address    = 32'h0000_0FFC;
                write_data = 32'h0000_0000;
            end
            if (ready6) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    // Cycle-exact access on the LATENCY=3 instance
    task automatic acc3(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rexp);
        logic [17:0] a_lo;
        a_lo = {a[18:2], 1'b0};
        wr3 = wr; rd3 = rd; a3 = a; d3 = d;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("l3_ready", {31'd0, ready3}, {31'd0, (c == 3)});
            if (c == 1 || c == 2) begin
                chk("l3_addr", {14'd0, addr3}, {14'd0, a_lo | 18'(c - 1)});
                chk("l3_we_oe", {30'd0, we3, oe3}, wr ? 32'd1 : 32'd2);
                if (wr) chk("l3_dq", {16'd0, dq3}, {16'd0, (c == 1) ? d[15:0] : d[31:16]});
            end
        end
        chk("l3_read_data", rdata3, rexp);
        @(posedge clk); #1;
        wr3 = 0; rd3 = 0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
        wr3 = 0; rd3 = 0; a3 = 0; d3 = 0;
        exp_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset state with no request
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", {31'd0, ready6}, 32'd1);
            chk("rst_strobes", {30'd0, we6, oe6}, 32'd3);
            chk("rst_addr", {14'd0, addr6}, 32'd0);
            chk("rst_read_data", rdata6, 32'd0);
        end
        @(posedge clk); #1;

        // Store then load of the same word
        do_access(1, 0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
        chk("mem_lo_0x082", {16'd0, mem6[8'h82]}, 32'h0000_BEEF);
        chk("mem_hi_0x083", {16'd0, mem6[8'h83]}, 32'h0000_DEAD);
        do_access(0, 1, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);

        // Seed a word, then load immediately followed by store
        do_access(1, 0, 32'h0000_0108, 32'h5678_1234, 32'h0, 0);
        do_access(0, 1, 32'h0000_0108, 32'h0, 32'h5678_1234, 0);
        do_access(1, 0, 32'h0000_010C, 32'hCAFE_F00D, 32'h0, 0);
        chk("mem_lo_0x086", {16'd0, mem6[8'h86]}, 32'h0000_F00D);

        // Ignored address bits and inputs changed mid-access
        do_access(1, 0, 32'hFFF8_0113, 32'h0BAD_CAFE, 32'h0, 1);
        do_access(0, 1, 32'h0000_0110, 32'h0, 32'h0BAD_CAFE, 0);

        // Reset during the HI phase of a store
        wr_en = 1; address = 32'h0000_0128; write_data = 32'h7777_8888;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; wr_en = 0;
        @(negedge clk);
        chk("pre_rst_hi_we", {31'd0, we6}, 32'd0);
        chk("pre_rst_hi_addr", {14'd0, addr6}, 32'h0000_0095);
        @(posedge clk); #1;
        rst = 0;
        exp_rd = 32'h0;
        @(negedge clk);
        chk("post_rst_we", {31'd0, we6}, 32'd1);
        chk("post_rst_addr", {14'd0, addr6}, 32'd0);
        chk("post_rst_read_data", rdata6, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {30'd0, ready6, we6}, 32'd3);
        end
        @(posedge clk); #1;
        do_access(0, 1, 32'h0000_0110, 32'h0, 32'h0BAD_CAFE, 0);

        // LATENCY = 3 instance: seed, read, write-wins, read back
        acc3(1, 0, 32'h0000_0104, 32'h5555_AAAA, 32'h0);
        acc3(0, 1, 32'h0000_0104, 32'h0, 32'h5555_AAAA);
        acc3(1, 1, 32'h0000_0104, 32'h1122_3344, 32'h5555_AAAA);
        chk("l3_mem_lo", {16'd0, mem3[8'h82]}, 32'h0000_3344);
        chk("l3_mem_hi", {16'd0, mem3[8'h83]}, 32'h0000_1122);
        acc3(0, 1, 32'h0000_0104, 32'h0, 32'h1122_3344);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
